// File: rtl/bv_decode_accum_pkg.sv
// Shared parameters for the countid encoder (calculate_countid) and the
// bit-vector decoder (bv_decode_accum). Both sides import these defaults so
// the encoder and decoder widths stay matched.
package bv_decode_accum_pkg;

  // Number of rules, which is also the width of the bit vector.
  localparam int width_bv_and_default = 64;
  // Width of a countid. width_bv_and must not exceed 2**width_count.
  localparam int width_count_default  = 6;

  // Bit offset of stage j's one-hot inside the flattened decode bus.
  // The one-hot vectors of stages 0..j-1 are 1,2,4,...,2**(j-1) bits wide,
  // so together they occupy 2**j - 1 bits.
  function automatic int stage_offset(input int j);
    return (1 << j) - 1;
  endfunction

endpackage

// File: rtl/bv_decode_stage.sv
// One stage of the MSB-first countid decoder.
// Stage `stage` expands the 2**(stage-1)-bit one-hot from the previous stage
// into a 2**stage-bit one-hot by steering each set bit according to
// countid[width_count-stage]. The id, valid and last flags ride along with
// the one-hot.
//
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   valid_in      previous stage holds a valid id
//   last_in       that id closes its set
//   id_in         full countid
//   onehot_in     2**(stage-1)-bit one-hot from the previous stage
//   valid_out, last_out, id_out, onehot_out   registered results
module bv_decode_stage #(
  parameter int stage       = 1,
  parameter int width_count = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_in,
  input  logic                     last_in,
  input  logic [width_count-1:0]   id_in,
  input  logic [(1<<(stage-1))-1:0] onehot_in,
  output logic                     valid_out,
  output logic                     last_out,
  output logic [width_count-1:0]   id_out,
  output logic [(1<<stage)-1:0]    onehot_out
);

  logic                  bit_sel;
  logic [(1<<stage)-1:0] onehot_next;

  assign bit_sel = id_in[width_count-stage];

  // Input bit i lands on output bit 2i or 2i+1, so after stage j the set
  // bit sits at index countid[width_count-1 : width_count-j].
  always_comb begin
    onehot_next = '0;
    for (int i = 0; i < (1 << (stage - 1)); i++) begin
      onehot_next[2*i]   = onehot_in[i] & ~bit_sel;
      onehot_next[2*i+1] = onehot_in[i] &  bit_sel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out  <= 1'b0;
      last_out   <= 1'b0;
      id_out     <= '0;
      onehot_out <= '0;
    end else begin
      valid_out  <= valid_in;
      last_out   <= last_in;
      id_out     <= id_in;
      onehot_out <= onehot_next;
    end
  end

endmodule

// File: rtl/bv_decode_accum.sv
// Decodes a stream of countids into a bit vector, one set at a time.
// Ids pass through width_count decode stages and are then ORed into an
// accumulator. When the id marked last reaches the accumulator, the completed
// vector is presented for one cycle together with duplicate and out-of-range
// flags. One id is accepted every cycle and there is no backpressure.
//
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   countid_valid  countid is valid on this cycle
//   countid        rule index to set
//   countid_last   this id closes the current set (qualified by valid)
//   bv_out_valid   one-cycle pulse marking a completed set
//   bv_out         accumulated bit vector (held between pulses)
//   dup_err        the set contained some id more than once
//   range_err      the set contained an id >= width_bv_and
module bv_decode_accum
  import bv_decode_accum_pkg::*;
#(
  parameter int width_bv_and = width_bv_and_default,
  parameter int width_count  = width_count_default
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    countid_valid,
  input  logic [width_count-1:0]  countid,
  input  logic                    countid_last,
  output logic                    bv_out_valid,
  output logic [width_bv_and-1:0] bv_out,
  output logic                    dup_err,
  output logic                    range_err
);

  // All stage one-hots are packed into one bus; stage 0 is the constant 1.
  localparam int flat_w = stage_offset(width_count + 1);

  logic [flat_w-1:0]      oh_flat;
  logic [width_count:0]   stg_valid;
  logic [width_count:0]   stg_last;
  logic [width_count-1:0] stg_id [0:width_count];

  assign oh_flat[0]   = 1'b1;
  assign stg_valid[0] = countid_valid;
  assign stg_last[0]  = countid_last;
  assign stg_id[0]    = countid;

  for (genvar j = 1; j <= width_count; j++) begin : g_stage
    bv_decode_stage #(
      .stage       (j),
      .width_count (width_count)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .valid_in   (stg_valid[j-1]),
      .last_in    (stg_last[j-1]),
      .id_in      (stg_id[j-1]),
      .onehot_in  (oh_flat[stage_offset(j-1) +: (1 << (j-1))]),
      .valid_out  (stg_valid[j]),
      .last_out   (stg_last[j]),
      .id_out     (stg_id[j]),
      .onehot_out (oh_flat[stage_offset(j) +: (1 << j)])
    );
  end

  logic                    dec_valid;
  logic                    dec_last;
  logic                    dec_range;
  logic [width_bv_and-1:0] dec_onehot;
  logic [width_bv_and-1:0] acc;
  logic                    dup_q;
  logic                    range_q;
  logic [width_bv_and-1:0] acc_next;
  logic                    dup_next;
  logic                    range_next;

  assign dec_valid = stg_valid[width_count];
  assign dec_last  = stg_last[width_count];
  // An out-of-range id decodes to a bit above width_bv_and; drop it so it
  // sets nothing, and flag the set instead.
  assign dec_range  = (32'(stg_id[width_count]) >= 32'(width_bv_and));
  assign dec_onehot = dec_range ? '0
                                : oh_flat[stage_offset(width_count) +: width_bv_and];

  assign acc_next   = acc | dec_onehot;
  assign dup_next   = dup_q | (|(acc & dec_onehot));
  assign range_next = range_q | dec_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      dup_q        <= 1'b0;
      range_q      <= 1'b0;
      bv_out_valid <= 1'b0;
      bv_out       <= '0;
      dup_err      <= 1'b0;
      range_err    <= 1'b0;
    end else begin
      bv_out_valid <= 1'b0;
      if (dec_valid) begin
        if (dec_last) begin
          // Publish the finished set and start the next one from zero.
          bv_out_valid <= 1'b1;
          bv_out       <= acc_next;
          dup_err      <= dup_next;
          range_err    <= range_next;
          acc          <= '0;
          dup_q        <= 1'b0;
          range_q      <= 1'b0;
        end else begin
          acc     <= acc_next;
          dup_q   <= dup_next;
          range_q <= range_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_bv_decode_accum.sv
module tb_bv_decode_accum;

  logic        clk;
  logic        reset;
  logic        countid_valid;
  logic [5:0]  countid;
  logic        countid_last;
  logic        bv_out_valid;
  logic [63:0] bv_out;
  logic        dup_err;
  logic        range_err;
  logic        bv_out_valid48;
  logic [47:0] bv_out48;
  logic        dup_err48;
  logic        range_err48;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [63:0] q_bv [$];
  logic        q_dup [$];
  logic        q_rng [$];
  int          q_cyc [$];
  logic [47:0] q48_bv [$];
  logic        q48_dup [$];
  logic        q48_rng [$];

  bv_decode_accum dut (
    .clk           (clk),
    .reset         (reset),
    .countid_valid (countid_valid),
    .countid       (countid),
    .countid_last  (countid_last),
    .bv_out_valid  (bv_out_valid),
    .bv_out        (bv_out),
    .dup_err       (dup_err),
    .range_err     (range_err)
  );

  bv_decode_accum #(.width_bv_and(48), .width_count(6)) dut48 (
    .clk           (clk),
    .reset         (reset),
    .countid_valid (countid_valid),
    .countid       (countid),
    .countid_last  (countid_last),
    .bv_out_valid  (bv_out_valid48),
    .bv_out        (bv_out48),
    .dup_err       (dup_err48),
    .range_err     (range_err48)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bv_out_valid === 1'b1) begin
      q_bv.push_back(bv_out);
      q_dup.push_back(dup_err);
      q_rng.push_back(range_err);
      q_cyc.push_back(cyc);
    end
    if (bv_out_valid48 === 1'b1) begin
      q48_bv.push_back(bv_out48);
      q48_dup.push_back(dup_err48);
      q48_rng.push_back(range_err48);
    end
  end

  task automatic clear_q();
    q_bv.delete(); q_dup.delete(); q_rng.delete(); q_cyc.delete();
    q48_bv.delete(); q48_dup.delete(); q48_rng.delete();
  endtask

  task automatic send(input logic [5:0] id, input logic last);
    @(negedge clk);
    countid_valid = 1'b1;
    countid       = id;
    countid_last  = last;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      countid_valid = 1'b0;
      countid_last  = 1'b0;
      countid       = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    countid_valid = 1'b0; countid = '0; countid_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bv_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bv_out_valid); end
    checks++; if (bv_out !== 64'h0) begin errors++; $display("FAIL reset_bv got=%h want=0", bv_out); end
    checks++; if (dup_err !== 1'b0) begin errors++; $display("FAIL reset_dup got=%b want=0", dup_err); end
    checks++; if (range_err !== 1'b0) begin errors++; $display("FAIL reset_range got=%b want=0", range_err); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    int t0;
    clear_q();
    send(6'd0, 1'b1);
    t0 = cyc;
    idle(10);
    checks++; if (q_bv.size() != 1) begin errors++; $display("FAIL single_count got=%0d want=1", q_bv.size()); end
    if (q_bv.size() >= 1) begin
      checks++; if (q_cyc[0] - t0 != 7) begin errors++; $display("FAIL single_latency got=%0d want=7", q_cyc[0] - t0); end
      checks++; if (q_bv[0] !== 64'h1) begin errors++; $display("FAIL single_bv got=%h want=1", q_bv[0]); end
      checks++; if (q_dup[0] !== 1'b0) begin errors++; $display("FAIL single_dup got=%b want=0", q_dup[0]); end
      checks++; if (q_rng[0] !== 1'b0) begin errors++; $display("FAIL single_range got=%b want=0", q_rng[0]); end
    end
  endtask

  task automatic test_set3();
    clear_q();
    send(6'd5, 1'b0);
    send(6'd63, 1'b0);
    send(6'd17, 1'b1);
    idle(10);
    checks++; if (q_bv.size() != 1) begin errors++; $display("FAIL set3_count got=%0d want=1", q_bv.size()); end
    if (q_bv.size() >= 1) begin
      checks++; if (q_bv[0] !== 64'h8000_0000_0002_0020) begin errors++; $display("FAIL set3_bv got=%h want=8000000000020020", q_bv[0]); end
      checks++; if (q_dup[0] !== 1'b0) begin errors++; $display("FAIL set3_dup got=%b want=0", q_dup[0]); end
    end
  endtask

  task automatic test_dup();
    clear_q();
    send(6'd9, 1'b0);
    send(6'd9, 1'b1);
    send(6'd1, 1'b1);
    idle(10);
    checks++; if (q_bv.size() != 2) begin errors++; $display("FAIL dup_count got=%0d want=2", q_bv.size()); end
    if (q_bv.size() >= 2) begin
      checks++; if (q_bv[0] !== 64'h200) begin errors++; $display("FAIL dup_bv0 got=%h want=200", q_bv[0]); end
      checks++; if (q_dup[0] !== 1'b1) begin errors++; $display("FAIL dup_flag0 got=%b want=1", q_dup[0]); end
      checks++; if (q_bv[1] !== 64'h2) begin errors++; $display("FAIL dup_bv1 got=%h want=2", q_bv[1]); end
      checks++; if (q_dup[1] !== 1'b0) begin errors++; $display("FAIL dup_flag1 got=%b want=0", q_dup[1]); end
    end
  endtask

  task automatic test_idle();
    clear_q();
    send(6'd2, 1'b0);
    idle(3);
    send(6'd4, 1'b1);
    idle(12);
    checks++; if (q_bv.size() != 1) begin errors++; $display("FAIL idle_count got=%0d want=1", q_bv.size()); end
    if (q_bv.size() >= 1) begin
      checks++; if (q_bv[0] !== 64'h14) begin errors++; $display("FAIL idle_bv got=%h want=14", q_bv[0]); end
      checks++; if (q_dup[0] !== 1'b0) begin errors++; $display("FAIL idle_dup got=%b want=0", q_dup[0]); end
    end
    checks++; if (bv_out !== 64'h14) begin errors++; $display("FAIL hold_bv got=%h want=14", bv_out); end
    checks++; if (bv_out_valid !== 1'b0) begin errors++; $display("FAIL hold_valid got=%b want=0", bv_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    clear_q();
    for (int i = 0; i < 64; i++) send(6'(i), 1'b1);
    idle(12);
    checks++; if (q_bv.size() != 64) begin errors++; $display("FAIL b2b_count got=%0d want=64", q_bv.size()); end
    if (q_bv.size() == 64) begin
      for (int i = 0; i < 64; i++) begin
        exp = 64'h1 << i;
        checks++; if (q_bv[i] !== exp) begin errors++; $display("FAIL b2b_bv[%0d] got=%h want=%h", i, q_bv[i], exp); end
        checks++; if (q_cyc[i] != q_cyc[0] + i) begin errors++; $display("FAIL b2b_cycle[%0d] got=%0d want=%0d", i, q_cyc[i], q_cyc[0] + i); end
      end
    end
  endtask

  task automatic test_width48();
    clear_q();
    send(6'd50, 1'b0);
    send(6'd2, 1'b1);
    send(6'd2, 1'b1);
    idle(10);
    checks++; if (q48_bv.size() != 2) begin errors++; $display("FAIL w48_count got=%0d want=2", q48_bv.size()); end
    if (q48_bv.size() >= 2) begin
      checks++; if (q48_bv[0] !== 48'h4) begin errors++; $display("FAIL w48_bv got=%h want=4", q48_bv[0]); end
      checks++; if (q48_rng[0] !== 1'b1) begin errors++; $display("FAIL w48_range got=%b want=1", q48_rng[0]); end
      checks++; if (q48_dup[0] !== 1'b0) begin errors++; $display("FAIL w48_dup got=%b want=0", q48_dup[0]); end
      checks++; if (q48_rng[1] !== 1'b0) begin errors++; $display("FAIL w48_range_clear got=%b want=0", q48_rng[1]); end
    end
  endtask

  task automatic test_reset_midset();
    clear_q();
    send(6'd3, 1'b0);
    send(6'd4, 1'b0);
    @(negedge clk);
    countid_valid = 1'b0;
    countid_last  = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (bv_out !== 64'h0) begin errors++; $display("FAIL midrst_bv_clear got=%h want=0", bv_out); end
    checks++; if (bv_out48 !== 48'h0) begin errors++; $display("FAIL midrst_bv48_clear got=%h want=0", bv_out48); end
    @(negedge clk);
    reset = 1'b0;
    send(6'd7, 1'b1);
    idle(12);
    checks++; if (q_bv.size() != 1) begin errors++; $display("FAIL midrst_count got=%0d want=1", q_bv.size()); end
    if (q_bv.size() >= 1) begin
      checks++; if (q_bv[0] !== 64'h80) begin errors++; $display("FAIL midrst_bv got=%h want=80", q_bv[0]); end
      checks++; if (q_dup[0] !== 1'b0) begin errors++; $display("FAIL midrst_dup got=%b want=0", q_dup[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_set3();
    test_dup();
    test_idle();
    test_back_to_back();
    test_width48();
    test_reset_midset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
